// File: rtl/multi_pattern_gen.sv
// Multi-channel test-sequence generator: shared bit-rate divider, per-channel
// clock / PRBS7 / PRBS15 / rotating-pattern output, config applied on bit boundaries.
module multi_pattern_gen #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int PAT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIV_W-1:0]    speedctr,
  input  logic [2*NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic [PAT_W-1:0]    pattern,
  input  logic                load,
  output logic                load_ack,
  output logic [NUM_CH-1:0]   bit_out,
  output logic                bit_strobe
);

  logic [DIV_W-1:0]    cnt;
  logic [DIV_W-1:0]    div_act, div_sh, div_nxt;
  logic [2*NUM_CH-1:0] mode_act, mode_sh, mode_nxt;
  logic [NUM_CH-1:0]   en_act, en_sh, en_nxt;
  logic [PAT_W-1:0]    pat_sh, pat_nxt;
  logic                pending;
  logic                tc, apply;

  logic [6:0]       prbs7   [NUM_CH];
  logic [14:0]      prbs15  [NUM_CH];
  logic [PAT_W-1:0] pat_reg [NUM_CH];

  assign tc    = (cnt == div_act);
  assign apply = tc && (pending || load);

  // A load landing on the terminal cycle applies straight from the inputs.
  assign div_nxt  = load ? speedctr : div_sh;
  assign mode_nxt = load ? mode     : mode_sh;
  assign en_nxt   = load ? ch_en    : en_sh;
  assign pat_nxt  = load ? pattern  : pat_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      div_act    <= '0;
      mode_act   <= '0;
      en_act     <= '0;
      div_sh     <= '0;
      mode_sh    <= '0;
      en_sh      <= '0;
      pat_sh     <= '0;
      pending    <= 1'b0;
      load_ack   <= 1'b0;
      bit_strobe <= 1'b0;
      bit_out    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        prbs7[i]   <= '1;
        prbs15[i]  <= '1;
        pat_reg[i] <= '0;
      end
    end else begin
      if (load) begin
        div_sh  <= speedctr;
        mode_sh <= mode;
        en_sh   <= ch_en;
        pat_sh  <= pattern;
      end

      if (apply) begin
        pending    <= 1'b0;
        div_act    <= div_nxt;
        mode_act   <= mode_nxt;
        en_act     <= en_nxt;
        cnt        <= '0;
        bit_out    <= '0;
        bit_strobe <= 1'b1;
        load_ack   <= 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          prbs7[i]   <= '1;
          prbs15[i]  <= '1;
          pat_reg[i] <= pat_nxt;
        end
      end else begin
        if (load) pending <= 1'b1;
        load_ack <= 1'b0;
        if (tc) begin
          cnt        <= '0;
          bit_strobe <= 1'b1;
          for (int i = 0; i < NUM_CH; i++) begin
            if (en_act[i]) begin
              case (mode_act[2*i +: 2])
                2'd0: bit_out[i] <= ~bit_out[i];
                2'd1: begin
                  bit_out[i] <= prbs7[i][6];
                  prbs7[i]   <= {prbs7[i][5:0], prbs7[i][6] ^ prbs7[i][5]};
                end
                2'd2: begin
                  bit_out[i] <= prbs15[i][14];
                  prbs15[i]  <= {prbs15[i][13:0], prbs15[i][14] ^ prbs15[i][13]};
                end
                default: begin
                  bit_out[i] <= pat_reg[i][PAT_W-1];
                  pat_reg[i] <= {pat_reg[i][PAT_W-2:0], pat_reg[i][PAT_W-1]};
                end
              endcase
            end else begin
              bit_out[i] <= 1'b0;
            end
          end
        end else begin
          cnt        <= cnt + DIV_W'(1);
          bit_strobe <= 1'b0;
        end
      end
    end
  end

endmodule
